// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_pkg : shared pipeline-control types and forwarding select codes     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package core_pkg;

  localparam int RIDX_W = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic [RIDX_W-1:0] rd;
    logic              regwrite;
    logic              memread;
  } shadow_slot_t;

  localparam shadow_slot_t SLOT_EMPTY = '0;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fwd_select : per-operand EX forwarding select, MEM slot beats WB slot    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module fwd_select import core_pkg::*; #(
  parameter int RIDX_W = 5
) (
  input  logic [RIDX_W-1:0] rs,
  input  logic              use_rs,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_regwrite,
  input  logic [RIDX_W-1:0] wb_rd,
  output logic [1:0]        sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  always_comb begin
    w_mem_hit = use_rs && mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
    w_wb_hit  = use_rs && wb_valid  && wb_regwrite  && (wb_rd  != '0) && (wb_rd  == rs);
    sel = FWD_REG;
    if (w_mem_hit) begin
      sel = FWD_EXMEM;
    end else if (w_wb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/idex_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | idex_hazard_unit : load-use stall, branch flush and EX forwarding control |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module idex_hazard_unit import core_pkg::*; #(
  parameter int XREGS  = 32,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  shadow_slot_t ex_q, ex_d;
  shadow_slot_t mem_q, mem_d;
  shadow_slot_t wb_q, wb_d;
  shadow_slot_t w_dec_entry;
  logic         w_rd_in_range;
  logic         w_load_use;
  logic         w_stall;
  logic         w_unused;

  // Invalid decode slots carry no side effects into the shadow pipeline.
  always_comb begin
    w_rd_in_range = ({1'b0, id_rd} < (RIDX_W+1)'(XREGS));
    w_dec_entry   = SLOT_EMPTY;
    if (id_valid) begin
      w_dec_entry.valid    = 1'b1;
      w_dec_entry.rs1      = id_rs1;
      w_dec_entry.rs2      = id_rs2;
      w_dec_entry.use_rs1  = id_use_rs1;
      w_dec_entry.use_rs2  = id_use_rs2;
      w_dec_entry.rd       = id_rd;
      w_dec_entry.regwrite = id_regwrite && w_rd_in_range;
      w_dec_entry.memread  = id_memread;
    end
  end

  always_comb begin
    w_load_use = id_valid && ex_q.memread && (ex_q.rd != '0) &&
                 ((id_use_rs1 && (ex_q.rd == id_rs1)) ||
                  (id_use_rs2 && (ex_q.rd == id_rs2)));
    w_stall    = w_load_use && !ex_branch_taken;
  end

  // Reset forces idle enables even while decode/branch inputs are active.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst_n) begin
      if (w_stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = idex_bubble ? SLOT_EMPTY : w_dec_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_select #(.RIDX_W(RIDX_W)) u_fwd_a (
    .rs           (ex_q.rs1),
    .use_rs       (ex_q.valid && ex_q.use_rs1),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .sel          (fwd_a)
  );

  fwd_select #(.RIDX_W(RIDX_W)) u_fwd_b (
    .rs           (ex_q.rs2),
    .use_rs       (ex_q.valid && ex_q.use_rs2),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .sel          (fwd_b)
  );

  // WB slot source fields are retired metadata with no consumer.
  assign w_unused = ^{wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2, wb_q.memread};

endmodule
`default_nettype wire

// File: tb/tb_idex_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_idex_hazard_unit : scoreboard bench with in-flight instruction model  |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_idex_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;

  idex_hazard_unit #(.XREGS(32), .RIDX_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit wr;
    bit ld;
  } ins_t;

  typedef struct {
    bit       pcw;
    bit       ifw;
    bit       fl;
    bit       bub;
    bit [1:0] fa;
    bit [1:0] fb;
    bit       mem_ld_fwd;
    string    tag;
  } exp_t;

  // pipe[0] is the instruction in EX, pipe[1] in MEM, pipe[2] in WB.
  ins_t pipe[3];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_stall = 0;
  bit   last_branch = 0;

  function automatic ins_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit wr, bit ld);
    ins_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
    t.rd = rd; t.wr = wr; t.ld = ld;
    return t;
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Walk older instructions youngest-first; the nearest writer of src wins.
  function automatic bit [1:0] fwd_for(int src, bit use_it);
    if (!pipe[0].v || !use_it || src == 0) return 2'b00;
    for (int d = 1; d <= 2; d++) begin
      if (pipe[d].v && pipe[d].wr && pipe[d].rd == src)
        return (d == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic ins_t rand_ins();
    int k = $urandom_range(0, 4);
    int a = $urandom_range(0, 7);
    int b = $urandom_range(0, 7);
    int d = $urandom_range(0, 7);
    case (k)
      1:       return mk(1, a, b, 1, 0, d, 1, 1);
      2:       return mk(1, a, b, 1, 1, d, 1, 0);
      3:       return mk(1, a, b, 1, 1, d, 0, 0);
      4:       return mk(1, a, b, 0, 0, d, 1, 0);
      default: return nop();
    endcase
  endfunction

  task automatic check(input exp_t e);
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b} !==
        {e.pcw, e.ifw, e.fl, e.bub, e.fa, e.fb}) begin
      errors++;
      $display("FAIL %s t=%0t: got pcw=%b ifw=%b flush=%b bub=%b fa=%b fb=%b, want pcw=%b ifw=%b flush=%b bub=%b fa=%b fb=%b",
               e.tag, $time, pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               e.pcw, e.ifw, e.fl, e.bub, e.fa, e.fb);
    end
  endtask

  function automatic exp_t idle_exp(string tag);
    exp_t e;
    e.pcw = 1; e.ifw = 1; e.fl = 0; e.bub = 0; e.fa = 2'b00; e.fb = 2'b00;
    e.mem_ld_fwd = 0; e.tag = tag;
    return e;
  endfunction

  task automatic issue(input bit rst, input ins_t ins, input bit br, input string tag);
    exp_t e;
    bit   hz = 0;
    bit   stall = 0;
    @(posedge clk);
    #1;
    rst_n = rst;
    id_valid = ins.v;
    id_rs1 = 5'(ins.rs1); id_rs2 = 5'(ins.rs2); id_rd = 5'(ins.rd);
    id_use_rs1 = ins.u1; id_use_rs2 = ins.u2;
    id_regwrite = ins.wr; id_memread = ins.ld;
    ex_branch_taken = br;
    e = idle_exp(tag);
    if (rst) begin
      hz = ins.v && pipe[0].ld && pipe[0].rd != 0 &&
           ((ins.u1 && pipe[0].rd == ins.rs1) || (ins.u2 && pipe[0].rd == ins.rs2));
      stall = hz && !br;
      e.pcw = !stall;
      e.ifw = !stall;
      e.fl  = br;
      e.bub = stall || br;
      e.fa  = fwd_for(pipe[0].rs1, pipe[0].u1);
      e.fb  = fwd_for(pipe[0].rs2, pipe[0].u2);
      e.mem_ld_fwd = pipe[1].ld && (e.fa == 2'b10 || e.fb == 2'b10);
    end
    sb.push_back(e);
    if (!rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = nop();
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (stall || br || !ins.v) ? nop() : ins;
    end
    last_stall  = rst && stall;
    last_branch = rst && br;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        assert (!e.mem_ld_fwd)
          else begin
            errors++;
            $display("FAIL mem_load_fwd %s: fwd_a=%b fwd_b=%b", e.tag, fwd_a, fwd_b);
          end
        check(e);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin : driver
    ins_t cur;
    bit   br;
    for (int i = 0; i < 3; i++) pipe[i] = nop();

    issue(0, mk(1, 5, 5, 1, 1, 5, 1, 1), 1, "reset_idle");
    issue(1, nop(), 0, "post_reset");

    // Load-use: one stall, one idle cycle, then WB forward.
    issue(1, mk(1, 1, 0, 1, 0, 5, 1, 1), 0, "lu_load");
    issue(1, mk(1, 5, 7, 1, 1, 6, 1, 0), 0, "lu_stall");
    issue(1, mk(1, 5, 7, 1, 1, 6, 1, 0), 0, "lu_held");
    issue(1, nop(), 0, "lu_fwd_wb");
    issue(1, nop(), 0, "lu_drain");

    // MEM wins over WB.
    issue(1, mk(1, 1, 2, 1, 1, 3, 1, 0), 0, "pri_add");
    issue(1, mk(1, 1, 2, 1, 1, 3, 1, 0), 0, "pri_sub");
    issue(1, mk(1, 3, 3, 1, 1, 4, 1, 0), 0, "pri_or");
    issue(1, nop(), 0, "pri_fwd_mem");
    issue(1, nop(), 0, "pri_drain");

    // x0 never forwards and never stalls.
    issue(1, mk(1, 1, 2, 1, 1, 0, 1, 1), 0, "x0_load");
    issue(1, mk(1, 0, 0, 1, 1, 8, 1, 0), 0, "x0_nostall");
    issue(1, mk(1, 0, 0, 1, 1, 9, 1, 0), 0, "x0_read");
    issue(1, nop(), 0, "x0_nofwd");
    issue(1, nop(), 0, "x0_drain");

    // Branch beats a simultaneous load-use.
    issue(1, mk(1, 1, 0, 1, 0, 5, 1, 1), 0, "br_load");
    issue(1, mk(1, 5, 7, 1, 1, 6, 1, 0), 1, "br_wins");
    issue(1, nop(), 0, "br_after");
    issue(1, nop(), 0, "br_drain");

    // Unused source fields do not stall.
    issue(1, mk(1, 1, 0, 1, 0, 5, 1, 1), 0, "use_load");
    issue(1, mk(1, 5, 5, 0, 0, 5, 1, 0), 0, "use_lui");
    issue(1, nop(), 0, "use_drain");

    // Async reset in the middle of a stall cycle.
    issue(1, mk(1, 1, 0, 1, 0, 5, 1, 1), 0, "rst_load");
    issue(1, mk(1, 5, 7, 1, 1, 6, 1, 0), 0, "rst_stall");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check(idle_exp("rst_async_idle"));
    for (int i = 0; i < 3; i++) pipe[i] = nop();
    issue(0, mk(1, 5, 7, 1, 1, 6, 1, 0), 0, "rst_hold");
    issue(1, mk(1, 5, 5, 1, 1, 6, 1, 0), 0, "rst_empty_ex");
    issue(1, nop(), 0, "rst_empty_fwd");
    issue(1, nop(), 0, "rst_drain");

    // Randomised program stream with held decode on stall, flushed decode after branch.
    cur = nop();
    for (int n = 0; n < 400; n++) begin
      if (last_stall) begin
        // decode holds the same instruction
      end else if (last_branch) begin
        cur = nop();
      end else begin
        cur = rand_ins();
      end
      br = ($urandom_range(0, 7) == 0);
      issue(($urandom_range(0, 59) != 0), cur, br, "rand");
    end
    issue(1, nop(), 0, "final");

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
